// File: rtl/sw_debounce_sync.sv
// Purpose: synchronize and debounce raw slide switches, then decode the clean vector into mode select fields.
// Latency: a pin change reaches sw_clean DB_LIMIT+2 edges after it is set up; mode_chg follows one edge later.
// Backpressure: none; free-running conditioning path with no handshake, and downstream samples levels every cycle.
module sw_debounce_sync #(
    parameter int WIDTH    = 4,
    parameter int DB_LIMIT = 1000000,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             mode_valid,
    output logic [1:0]       mode_code,
    output logic             mode_chg
);

    // Terminal count: a bit that has disagreed for this many cycles is accepted on the next edge.
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(DB_LIMIT - 1);

    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_s2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] prev_clean;

    logic [3:0]       low4;
    logic             upper_zero;
    logic             onehot_hit;
    logic [1:0]       onehot_idx;

    // Two-flop synchronizer; sw_raw is asynchronous to clk, so only sync_s2 feeds logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= sw_raw;
            sync_s2 <= sync_s1;
        end
    end

    // Per-bit stability counters; any cycle of agreement discards the partial count so bounce restarts the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_clean <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s2[i] == sw_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LIM_M1) begin
                    sw_clean[i] <= sync_s2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Change detector: compares the clean vector with its one-cycle-old copy, giving a single pulse per update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_clean <= '0;
            mode_chg   <= 1'b0;
        end else begin
            prev_clean <= sw_clean;
            mode_chg   <= (prev_clean != sw_clean);
        end
    end

    assign low4 = sw_clean[3:0];

    // Extra switches beyond the four decoded ones must be off for the mode to count as valid.
    generate
        if (WIDTH > 4) begin : g_upper
            assign upper_zero = ~|sw_clean[WIDTH-1:4];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    // One-hot decode of the low four clean bits into a valid flag and a 2-bit index.
    always_comb begin
        onehot_hit = 1'b0;
        onehot_idx = 2'd0;
        case (low4)
            4'b0001: begin onehot_hit = 1'b1; onehot_idx = 2'd0; end
            4'b0010: begin onehot_hit = 1'b1; onehot_idx = 2'd1; end
            4'b0100: begin onehot_hit = 1'b1; onehot_idx = 2'd2; end
            4'b1000: begin onehot_hit = 1'b1; onehot_idx = 2'd3; end
            default: begin onehot_hit = 1'b0; onehot_idx = 2'd0; end
        endcase
    end

    assign mode_valid = onehot_hit & upper_zero;
    assign mode_code  = mode_valid ? onehot_idx : 2'd0;

endmodule

// File: tb/tb_sw_debounce_sync.sv
module tb_sw_debounce_sync;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_clean;
    logic       mode_valid;
    logic [1:0] mode_code;
    logic       mode_chg;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] exp_clean;
        logic       exp_valid;
        logic [1:0] exp_code;
    } vec_t;

    vec_t tbl [16];

    sw_debounce_sync #(
        .WIDTH    (4),
        .DB_LIMIT (8),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .mode_valid (mode_valid),
        .mode_code  (mode_code),
        .mode_chg   (mode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Apply raw, then check hold for 9 edges, update on the 10th, pulse on the 11th, quiet on the 12th.
    task automatic lat(input string nm, input logic [3:0] raw,
                       input logic [3:0] old_c, input logic old_v, input logic [1:0] old_code,
                       input logic [3:0] new_c, input logic new_v, input logic [1:0] new_code);
        sw_raw = raw;
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk({nm, "_hold_clean"}, 32'(sw_clean), 32'(old_c));
            chk({nm, "_hold_valid"}, 32'(mode_valid), 32'(old_v));
            chk({nm, "_hold_code"}, 32'(mode_code), 32'(old_code));
            chk({nm, "_hold_chg"}, 32'(mode_chg), 32'd0);
        end
        tick();
        chk({nm, "_upd_clean"}, 32'(sw_clean), 32'(new_c));
        chk({nm, "_upd_valid"}, 32'(mode_valid), 32'(new_v));
        chk({nm, "_upd_code"}, 32'(mode_code), 32'(new_code));
        chk({nm, "_upd_chg"}, 32'(mode_chg), 32'd0);
        tick();
        chk({nm, "_pulse_chg"}, 32'(mode_chg), 32'd1);
        chk({nm, "_pulse_clean"}, 32'(sw_clean), 32'(new_c));
        tick();
        chk({nm, "_end_chg"}, 32'(mode_chg), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0]  = '{4'h0, 4'h0, 1'b0, 2'd0};
        tbl[1]  = '{4'h1, 4'h1, 1'b1, 2'd0};
        tbl[2]  = '{4'h2, 4'h2, 1'b1, 2'd1};
        tbl[3]  = '{4'h3, 4'h3, 1'b0, 2'd0};
        tbl[4]  = '{4'h4, 4'h4, 1'b1, 2'd2};
        tbl[5]  = '{4'h5, 4'h5, 1'b0, 2'd0};
        tbl[6]  = '{4'h6, 4'h6, 1'b0, 2'd0};
        tbl[7]  = '{4'h7, 4'h7, 1'b0, 2'd0};
        tbl[8]  = '{4'h8, 4'h8, 1'b1, 2'd3};
        tbl[9]  = '{4'h9, 4'h9, 1'b0, 2'd0};
        tbl[10] = '{4'hA, 4'hA, 1'b0, 2'd0};
        tbl[11] = '{4'hB, 4'hB, 1'b0, 2'd0};
        tbl[12] = '{4'hC, 4'hC, 1'b0, 2'd0};
        tbl[13] = '{4'hD, 4'hD, 1'b0, 2'd0};
        tbl[14] = '{4'hE, 4'hE, 1'b0, 2'd0};
        tbl[15] = '{4'hF, 4'hF, 1'b0, 2'd0};

        // Reset with all switches on, then release and wait for acceptance.
        rst_n  = 1'b0;
        sw_raw = 4'hF;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("rst_clean", 32'(sw_clean), 32'h0);
            chk("rst_valid", 32'(mode_valid), 32'h0);
            chk("rst_code", 32'(mode_code), 32'h0);
            chk("rst_chg", 32'(mode_chg), 32'h0);
        end
        rst_n = 1'b1;
        lat("t1_all_on", 4'hF, 4'h0, 1'b0, 2'd0, 4'hF, 1'b0, 2'd0);

        // Clear, then a clean single-bit step.
        lat("t2_clear", 4'h0, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
        lat("t2_step", 4'b0010, 4'h0, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1);
        lat("t3_clear", 4'h0, 4'b0010, 1'b1, 2'd1, 4'h0, 1'b0, 2'd0);

        // Bounce on bit0: never held long enough to be accepted.
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) sw_raw[0] = ~sw_raw[0];
            tick();
            chk("t3_bounce_clean", 32'(sw_clean), 32'h0);
            chk("t3_bounce_chg", 32'(mode_chg), 32'h0);
        end
        lat("t3_final", 4'b0001, 4'h0, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0);

        // Two bits move together: one update, mode stays valid.
        lat("t4_swap", 4'b0100, 4'b0001, 1'b1, 2'd0, 4'b0100, 1'b1, 2'd2);

        // Reset while counting toward a new value discards the partial count.
        lat("t5_clear", 4'h0, 4'b0100, 1'b1, 2'd2, 4'h0, 1'b0, 2'd0);
        sw_raw = 4'b1000;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("t5_pre_clean", 32'(sw_clean), 32'h0);
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_clean", 32'(sw_clean), 32'h0);
        chk("t5_rst_chg", 32'(mode_chg), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        lat("t5_after", 4'b1000, 4'h0, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3);

        // Two bits set: not a valid mode.
        lat("t6_two", 4'b0011, 4'b1000, 1'b1, 2'd3, 4'b0011, 1'b0, 2'd0);

        // Settled decode of every switch combination.
        for (int v = 0; v < 16; v++) begin
            sw_raw = tbl[v].raw;
            for (int t = 0; t < 14; t++) tick();
            chk("tbl_clean", 32'(sw_clean), 32'(tbl[v].exp_clean));
            chk("tbl_valid", 32'(mode_valid), 32'(tbl[v].exp_valid));
            chk("tbl_code", 32'(mode_code), 32'(tbl[v].exp_code));
            chk("tbl_chg", 32'(mode_chg), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
